mp_icache_ctrl_sequencer: RTL and testbench

Cache-side consumer of the multi-port icache control bus, sitting between the cluster icache control unit and the private/shared icache banks. Turns level requests for bypass, full flush and selective flush into per-bank request/ack sequences and returns aggregated acks with a 4-phase handshake. Also keeps the global and per-bank hit/transaction/miss statistics counters that the control unit reads back.

---
 rtl/mp_icache_ctrl_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_mp_icache_ctrl_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mp_icache_ctrl_sequencer.sv
// Cache-side icache control sequencer: fans flush/selective-flush requests out to the banks,
// aggregates their acks into 4-phase handshakes, generates bypass acks and keeps hit/trans/miss stats.
module mp_icache_ctrl_sequencer #(
    parameter int NB_CORES = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           bypass_req_i,
    output logic [NB_CORES:0]              bypass_ack_o,
    input  logic                           flush_req_i,
    output logic                           flush_ack_o,
    input  logic                           sel_flush_req_i,
    input  logic [31:0]                    sel_flush_addr_i,
    output logic                           sel_flush_ack_o,
    input  logic                           ctrl_clear_regs_i,
    input  logic                           ctrl_enable_regs_i,
    output logic [31:0]                    global_hit_count_o,
    output logic [31:0]                    global_trans_count_o,
    output logic [31:0]                    global_miss_count_o,
    output logic [NB_CORES-1:0][31:0]      bank_hit_count_o,
    output logic [NB_CORES-1:0][31:0]      bank_trans_count_o,
    output logic [NB_CORES-1:0][31:0]      bank_miss_count_o,
    output logic                           bypass_en_o,
    input  logic [NB_CORES:0]              fetch_idle_i,
    output logic [NB_CORES-1:0]            bank_flush_req_o,
    input  logic [NB_CORES-1:0]            bank_flush_ack_i,
    output logic [NB_CORES-1:0]            bank_sel_flush_req_o,
    output logic [31:0]                    bank_sel_flush_addr_o,
    input  logic [NB_CORES-1:0]            bank_sel_flush_ack_i,
    input  logic [NB_CORES-1:0]            bank_trans_i,
    input  logic [NB_CORES-1:0]            bank_hit_i,
    input  logic [NB_CORES-1:0]            bank_miss_i
);

    typedef enum logic [2:0] {IDLE, FLUSH, FLUSH_DONE, SEL, SEL_DONE} state_e;

    state_e                     state_q, state_d;
    logic [NB_CORES-1:0]        mask_q, mask_d;
    logic [NB_CORES-1:0]        flush_req_q, flush_req_d;
    logic [NB_CORES-1:0]        sel_req_q, sel_req_d;
    logic [31:0]                sel_addr_q, sel_addr_d;
    logic                       flush_ack_q, flush_ack_d;
    logic                       sel_ack_q, sel_ack_d;
    logic                       bypass_en_q;
    logic [NB_CORES:0]          bypass_ack_q, bypass_ack_d;
    logic [31:0]                g_hit_q, g_hit_d, g_trans_q, g_trans_d, g_miss_q, g_miss_d;
    logic [NB_CORES-1:0][31:0]  b_hit_q, b_hit_d, b_trans_q, b_trans_d, b_miss_q, b_miss_d;
    logic [NB_CORES-1:0]        mask_all;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic logic [31:0] popcount(input logic [NB_CORES-1:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < NB_CORES; i++) c = c + 32'(v[i]);
        return c;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            flush_req_q  <= '0;
            sel_req_q    <= '0;
            sel_addr_q   <= '0;
            flush_ack_q  <= 1'b0;
            sel_ack_q    <= 1'b0;
            bypass_en_q  <= 1'b0;
            bypass_ack_q <= '0;
            g_hit_q      <= '0;
            g_trans_q    <= '0;
            g_miss_q     <= '0;
            b_hit_q      <= '0;
            b_trans_q    <= '0;
            b_miss_q     <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            flush_req_q  <= flush_req_d;
            sel_req_q    <= sel_req_d;
            sel_addr_q   <= sel_addr_d;
            flush_ack_q  <= flush_ack_d;
            sel_ack_q    <= sel_ack_d;
            bypass_en_q  <= bypass_req_i;
            bypass_ack_q <= bypass_ack_d;
            g_hit_q      <= g_hit_d;
            g_trans_q    <= g_trans_d;
            g_miss_q     <= g_miss_d;
            b_hit_q      <= b_hit_d;
            b_trans_q    <= b_trans_d;
            b_miss_q     <= b_miss_d;
        end
    end

    // Acks are only meaningful while the matching operation is in flight.
    always_comb begin
        mask_all = '0;
        if (state_q == FLUSH)    mask_all = mask_q | bank_flush_ack_i;
        else if (state_q == SEL) mask_all = mask_q | bank_sel_flush_ack_i;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush_req_i)          state_d = FLUSH;
                else if (sel_flush_req_i) state_d = SEL;
            end
            FLUSH:      if (&mask_all)        state_d = FLUSH_DONE;
            FLUSH_DONE: if (!flush_req_i)     state_d = IDLE;
            SEL:        if (&mask_all)        state_d = SEL_DONE;
            SEL_DONE:   if (!sel_flush_req_i) state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_comb begin
        mask_d      = '0;
        flush_req_d = '0;
        sel_req_d   = '0;
        sel_addr_d  = sel_addr_q;
        flush_ack_d = (state_d == FLUSH_DONE);
        sel_ack_d   = (state_d == SEL_DONE);
        case (state_q)
            IDLE: begin
                if (flush_req_i) begin
                    flush_req_d = '1;
                end else if (sel_flush_req_i) begin
                    sel_req_d  = '1;
                    sel_addr_d = sel_flush_addr_i;
                end
            end
            FLUSH: begin
                flush_req_d = flush_req_q & ~bank_flush_ack_i;
                mask_d      = (&mask_all) ? '0 : mask_all;
            end
            SEL: begin
                sel_req_d = sel_req_q & ~bank_sel_flush_ack_i;
                mask_d    = (&mask_all) ? '0 : mask_all;
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i <= NB_CORES; i++)
            bypass_ack_d[i] = bypass_req_i & bypass_en_q & (bypass_ack_q[i] | fetch_idle_i[i]);
    end

    // Clear has priority over counting; every counter saturates instead of wrapping.
    always_comb begin
        g_hit_d   = g_hit_q;
        g_trans_d = g_trans_q;
        g_miss_d  = g_miss_q;
        b_hit_d   = b_hit_q;
        b_trans_d = b_trans_q;
        b_miss_d  = b_miss_q;
        if (ctrl_clear_regs_i) begin
            g_hit_d   = '0;
            g_trans_d = '0;
            g_miss_d  = '0;
            b_hit_d   = '0;
            b_trans_d = '0;
            b_miss_d  = '0;
        end else if (ctrl_enable_regs_i) begin
            g_hit_d   = sat_add(g_hit_q,   popcount(bank_hit_i));
            g_trans_d = sat_add(g_trans_q, popcount(bank_trans_i));
            g_miss_d  = sat_add(g_miss_q,  popcount(bank_miss_i));
            for (int b = 0; b < NB_CORES; b++) begin
                b_hit_d[b]   = sat_add(b_hit_q[b],   32'(bank_hit_i[b]));
                b_trans_d[b] = sat_add(b_trans_q[b], 32'(bank_trans_i[b]));
                b_miss_d[b]  = sat_add(b_miss_q[b],  32'(bank_miss_i[b]));
            end
        end
    end

    assign bypass_en_o           = bypass_en_q;
    assign bypass_ack_o          = bypass_ack_q;
    assign flush_ack_o           = flush_ack_q;
    assign sel_flush_ack_o       = sel_ack_q;
    assign bank_flush_req_o      = flush_req_q;
    assign bank_sel_flush_req_o  = sel_req_q;
    assign bank_sel_flush_addr_o = sel_addr_q;
    assign global_hit_count_o    = g_hit_q;
    assign global_trans_count_o  = g_trans_q;
    assign global_miss_count_o   = g_miss_q;
    assign bank_hit_count_o      = b_hit_q;
    assign bank_trans_count_o    = b_trans_q;
    assign bank_miss_count_o     = b_miss_q;

endmodule

// File: tb/tb_mp_icache_ctrl_sequencer.sv
// Directed self-checking bench for mp_icache_ctrl_sequencer (NB_CORES = 4).
module tb_mp_icache_ctrl_sequencer;

    localparam int NB = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              bypass_req_i;
    logic [NB:0]       bypass_ack_o;
    logic              flush_req_i;
    logic              flush_ack_o;
    logic              sel_flush_req_i;
    logic [31:0]       sel_flush_addr_i;
    logic              sel_flush_ack_o;
    logic              ctrl_clear_regs_i;
    logic              ctrl_enable_regs_i;
    logic [31:0]       global_hit_count_o, global_trans_count_o, global_miss_count_o;
    logic [NB-1:0][31:0] bank_hit_count_o, bank_trans_count_o, bank_miss_count_o;
    logic              bypass_en_o;
    logic [NB:0]       fetch_idle_i;
    logic [NB-1:0]     bank_flush_req_o;
    logic [NB-1:0]     bank_flush_ack_i;
    logic [NB-1:0]     bank_sel_flush_req_o;
    logic [31:0]       bank_sel_flush_addr_o;
    logic [NB-1:0]     bank_sel_flush_ack_i;
    logic [NB-1:0]     bank_trans_i, bank_hit_i, bank_miss_i;

    int n_checks = 0;
    int n_errors = 0;

    mp_icache_ctrl_sequencer #(.NB_CORES(NB)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .bypass_req_i(bypass_req_i), .bypass_ack_o(bypass_ack_o),
        .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
        .sel_flush_req_i(sel_flush_req_i), .sel_flush_addr_i(sel_flush_addr_i),
        .sel_flush_ack_o(sel_flush_ack_o),
        .ctrl_clear_regs_i(ctrl_clear_regs_i), .ctrl_enable_regs_i(ctrl_enable_regs_i),
        .global_hit_count_o(global_hit_count_o), .global_trans_count_o(global_trans_count_o),
        .global_miss_count_o(global_miss_count_o),
        .bank_hit_count_o(bank_hit_count_o), .bank_trans_count_o(bank_trans_count_o),
        .bank_miss_count_o(bank_miss_count_o),
        .bypass_en_o(bypass_en_o), .fetch_idle_i(fetch_idle_i),
        .bank_flush_req_o(bank_flush_req_o), .bank_flush_ack_i(bank_flush_ack_i),
        .bank_sel_flush_req_o(bank_sel_flush_req_o), .bank_sel_flush_addr_o(bank_sel_flush_addr_o),
        .bank_sel_flush_ack_i(bank_sel_flush_ack_i),
        .bank_trans_i(bank_trans_i), .bank_hit_i(bank_hit_i), .bank_miss_i(bank_miss_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are read at the same point.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        bypass_req_i = 0; flush_req_i = 0; sel_flush_req_i = 0; sel_flush_addr_i = '0;
        ctrl_clear_regs_i = 0; ctrl_enable_regs_i = 0; fetch_idle_i = '0;
        bank_flush_ack_i = '0; bank_sel_flush_ack_i = '0;
        bank_trans_i = '0; bank_hit_i = '0; bank_miss_i = '0;
        tick(2);
        check("rst_flush_req", 32'(bank_flush_req_o), 32'h0);
        check("rst_bypass_ack", 32'(bypass_ack_o), 32'h0);
        check("rst_gtrans", global_trans_count_o, 32'h0);
        rst_ni = 1'b1;
        tick();

        // Full flush with staggered bank acks, including a repeat ack for bank 0
        flush_req_i = 1;
        tick();
        check("fl_req_all", 32'(bank_flush_req_o), 32'hF);
        tick(2);
        bank_flush_ack_i = 4'b0001; tick(); bank_flush_ack_i = '0;
        check("fl_req_b0", 32'(bank_flush_req_o), 32'hE);
        tick();
        bank_flush_ack_i = 4'b0111; tick(); bank_flush_ack_i = '0;
        check("fl_req_b12", 32'(bank_flush_req_o), 32'h8);
        check("fl_ack_early", 32'(flush_ack_o), 32'h0);
        tick(3);
        bank_flush_ack_i = 4'b1000; tick(); bank_flush_ack_i = '0;
        check("fl_req_none", 32'(bank_flush_req_o), 32'h0);
        check("fl_ack_set", 32'(flush_ack_o), 32'h1);
        tick();
        check("fl_ack_hold", 32'(flush_ack_o), 32'h1);
        flush_req_i = 0; tick();
        check("fl_ack_drop", 32'(flush_ack_o), 32'h0);

        // Stray acks in IDLE, then simultaneous flush + selective flush
        bank_flush_ack_i = 4'hF; tick(); bank_flush_ack_i = '0;
        flush_req_i = 1; sel_flush_req_i = 1; sel_flush_addr_i = 32'h1C00_0040;
        tick();
        check("sim_fl_req", 32'(bank_flush_req_o), 32'hF);
        check("sim_sel_req_wait", 32'(bank_sel_flush_req_o), 32'h0);
        sel_flush_addr_i = 32'hDEAD_BEEF;
        bank_flush_ack_i = 4'hF; tick(); bank_flush_ack_i = '0;
        check("sim_fl_ack", 32'(flush_ack_o), 32'h1);
        flush_req_i = 0; sel_flush_addr_i = 32'h1C00_0040; tick();
        check("sim_fl_ack_drop", 32'(flush_ack_o), 32'h0);
        tick();
        check("sim_sel_req", 32'(bank_sel_flush_req_o), 32'hF);
        check("sim_sel_addr", bank_sel_flush_addr_o, 32'h1C00_0040);
        sel_flush_addr_i = 32'h0;
        bank_sel_flush_ack_i = 4'b0101; tick(); bank_sel_flush_ack_i = '0;
        check("sim_sel_part", 32'(bank_sel_flush_req_o), 32'hA);
        check("sim_sel_ack_early", 32'(sel_flush_ack_o), 32'h0);
        bank_sel_flush_ack_i = 4'b1010; tick(); bank_sel_flush_ack_i = '0;
        check("sim_sel_ack", 32'(sel_flush_ack_o), 32'h1);
        check("sim_sel_addr_hold", bank_sel_flush_addr_o, 32'h1C00_0040);
        sel_flush_req_i = 0; tick();
        check("sim_sel_ack_drop", 32'(sel_flush_ack_o), 32'h0);

        // Bypass with port 0 going idle late
        fetch_idle_i = 5'b10110; bypass_req_i = 1;
        tick();
        check("byp_en", 32'(bypass_en_o), 32'h1);
        check("byp_ack_c1", 32'(bypass_ack_o), 32'h0);
        tick();
        check("byp_ack_c2", 32'(bypass_ack_o), 32'h16);
        tick(2);
        fetch_idle_i = 5'b10111; tick();
        check("byp_ack_p0", 32'(bypass_ack_o), 32'h17);
        fetch_idle_i = 5'b00000; tick();
        check("byp_ack_sticky", 32'(bypass_ack_o), 32'h17);
        bypass_req_i = 0; tick();
        check("byp_ack_drop", 32'(bypass_ack_o), 32'h0);
        check("byp_en_drop", 32'(bypass_en_o), 32'h0);

        // Statistics counters
        ctrl_enable_regs_i = 1; bank_hit_i = 4'b1011;
        tick();
        check("cnt_ghit_1", global_hit_count_o, 32'd3);
        tick(9);
        bank_hit_i = '0;
        check("cnt_ghit_10", global_hit_count_o, 32'd30);
        check("cnt_bhit0", bank_hit_count_o[0], 32'd10);
        check("cnt_bhit1", bank_hit_count_o[1], 32'd10);
        check("cnt_bhit2", bank_hit_count_o[2], 32'd0);
        check("cnt_bhit3", bank_hit_count_o[3], 32'd10);
        check("cnt_gtrans_0", global_trans_count_o, 32'd0);
        ctrl_enable_regs_i = 0; bank_hit_i = 4'hF; bank_miss_i = 4'b0100; tick();
        check("cnt_hold", global_hit_count_o, 32'd30);
        ctrl_enable_regs_i = 1; tick();
        check("cnt_miss", bank_miss_count_o[2], 32'd1);
        check("cnt_ghit_34", global_hit_count_o, 32'd34);
        ctrl_clear_regs_i = 1; tick();
        ctrl_clear_regs_i = 0; bank_hit_i = '0; bank_miss_i = '0;
        check("clr_ghit", global_hit_count_o, 32'd0);
        check("clr_bhit3", bank_hit_count_o[3], 32'd0);
        check("clr_gmiss", global_miss_count_o, 32'd0);

        // Saturation of the global transaction counter
        force dut.g_trans_q = 32'hFFFF_FFFE;
        #1;
        release dut.g_trans_q;
        bank_trans_i = 4'hF; tick();
        check("sat_gtrans", global_trans_count_o, 32'hFFFF_FFFF);
        tick();
        check("sat_gtrans_nowrap", global_trans_count_o, 32'hFFFF_FFFF);
        check("sat_btrans", bank_trans_count_o[1], 32'd2);
        bank_trans_i = '0; ctrl_enable_regs_i = 0;

        // Reset in the middle of a flush with two acks collected
        flush_req_i = 1; tick();
        bank_flush_ack_i = 4'b0011; tick(); bank_flush_ack_i = '0;
        check("rf_req_part", 32'(bank_flush_req_o), 32'hC);
        rst_ni = 1'b0; #1;
        check("rf_req_rst", 32'(bank_flush_req_o), 32'h0);
        check("rf_ack_rst", 32'(flush_ack_o), 32'h0);
        check("rf_gtrans_rst", global_trans_count_o, 32'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("rf_req_new", 32'(bank_flush_req_o), 32'hF);
        bank_flush_ack_i = 4'b0111; tick(); bank_flush_ack_i = '0;
        check("rf_ack_3of4", 32'(flush_ack_o), 32'h0);
        check("rf_req_b3", 32'(bank_flush_req_o), 32'h8);
        bank_flush_ack_i = 4'b1000; tick(); bank_flush_ack_i = '0;
        check("rf_ack_done", 32'(flush_ack_o), 32'h1);
        flush_req_i = 0; tick();
        check("rf_ack_drop", 32'(flush_ack_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
